// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and default sizing for the pipeline stall/flush controller.
package pipeline_ctrl_pkg;

    localparam int unsigned MEM_TIMEOUT = 255;
    localparam int unsigned CNT_W       = 16;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } pipe_state_e;

endpackage

// File: rtl/pipeline_controller_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_controller.sv
// Pipeline hazard controller: memory-stall FSM with timeout, same-cycle
// freeze/flush/bubble decode and saturating stall/flush statistics.
module pipeline_controller #(
    parameter int unsigned MEM_TIMEOUT = pipeline_ctrl_pkg::MEM_TIMEOUT,
    parameter int unsigned CNT_W       = pipeline_ctrl_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hazard_detected,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             clr_err,
    output logic             freeze_pc,
    output logic             freeze_if_id,
    output logic             freeze_id_exe,
    output logic             freeze_exe_mem,
    output logic             flush_if_id,
    output logic             bubble_id_exe,
    output logic             bubble_mem_wb,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic             timeout_err
);

    import pipeline_ctrl_pkg::*;

    localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

    pipe_state_e       state_q;
    pipe_state_e       state_d;
    logic [WAIT_W-1:0] wait_cnt_q;
    logic [WAIT_W-1:0] wait_cnt_d;
    logic              timeout_err_q;
    logic              timeout_err_d;

    logic mem_busy;
    logic freeze_all;

    assign mem_busy   = mem_req & ~mem_ready;
    assign freeze_all = mem_busy | (state_q == ERR);

    // Next-state logic; wait_cnt stops at WAIT_MAX, so it cannot wrap.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            RUN: begin
                if (mem_busy) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WAIT_ONE;
                end
            end
            MEM_WAIT: begin
                if (!mem_busy) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_MAX) begin
                    state_d       = ERR;
                    timeout_err_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_ONE;
                end
            end
            ERR: begin
                if (clr_err) begin
                    state_d       = RUN;
                    wait_cnt_d    = '0;
                    timeout_err_d = 1'b0;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            wait_cnt_q    <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // A branch seen during a freeze is not remembered: it acts once the freeze drops.
    always_comb begin
        freeze_pc      = 1'b0;
        freeze_if_id   = 1'b0;
        freeze_id_exe  = 1'b0;
        freeze_exe_mem = 1'b0;
        flush_if_id    = 1'b0;
        bubble_id_exe  = 1'b0;
        bubble_mem_wb  = 1'b0;
        if (freeze_all) begin
            freeze_pc      = 1'b1;
            freeze_if_id   = 1'b1;
            freeze_id_exe  = 1'b1;
            freeze_exe_mem = 1'b1;
            bubble_mem_wb  = 1'b1;
        end else if (branch_taken) begin
            flush_if_id   = 1'b1;
            bubble_id_exe = 1'b1;
        end else if (hazard_detected) begin
            freeze_pc     = 1'b1;
            freeze_if_id  = 1'b1;
            bubble_id_exe = 1'b1;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (freeze_pc),
        .count (stall_cycles)
    );

    sat_counter #(
        .W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_if_id),
        .count (flush_events)
    );

    assign state       = state_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pipeline_controller.sv
// Scoreboard bench for pipeline_controller with a short timeout and 4-bit counters.
module tb_pipeline_controller;

    localparam int unsigned TO = 4;
    localparam int unsigned CW = 4;

    logic clk;
    logic rst;
    logic hazard_detected;
    logic branch_taken;
    logic mem_req;
    logic mem_ready;
    logic clr_err;
    logic freeze_pc;
    logic freeze_if_id;
    logic freeze_id_exe;
    logic freeze_exe_mem;
    logic flush_if_id;
    logic bubble_id_exe;
    logic bubble_mem_wb;
    logic [1:0] state;
    logic [CW-1:0] stall_cycles;
    logic [CW-1:0] flush_events;
    logic timeout_err;

    logic [6:0] ctrl;
    assign ctrl = {freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem,
                   flush_if_id, bubble_id_exe, bubble_mem_wb};

    pipeline_controller #(
        .MEM_TIMEOUT (TO),
        .CNT_W       (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .clr_err         (clr_err),
        .freeze_pc       (freeze_pc),
        .freeze_if_id    (freeze_if_id),
        .freeze_id_exe   (freeze_id_exe),
        .freeze_exe_mem  (freeze_exe_mem),
        .flush_if_id     (flush_if_id),
        .bubble_id_exe   (bubble_id_exe),
        .bubble_mem_wb   (bubble_mem_wb),
        .state           (state),
        .stall_cycles    (stall_cycles),
        .flush_events    (flush_events),
        .timeout_err     (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]    ctrl;
        logic [1:0]    st;
        logic [CW-1:0] stall;
        logic [CW-1:0] flush;
        logic          terr;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [1:0]    m_state;
    int unsigned   m_wait;
    logic          m_err;
    logic [CW-1:0] m_stall;
    logic [CW-1:0] m_flush;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] model_ctrl(input logic hz, input logic br,
                                              input logic mq, input logic mr);
        logic busy;
        busy = mq & ~mr;
        if (busy || (m_state == 2'd2)) return 7'b1111001;
        else if (br)                   return 7'b0000110;
        else if (hz)                   return 7'b1100010;
        else                           return 7'b0000000;
    endfunction

    task automatic model_reset();
        m_state = 2'd0;
        m_wait  = 0;
        m_err   = 1'b0;
        m_stall = '0;
        m_flush = '0;
    endtask

    task automatic model_advance(input logic hz, input logic br, input logic mq,
                                 input logic mr, input logic ce);
        logic [6:0] c;
        logic busy;
        c    = model_ctrl(hz, br, mq, mr);
        busy = mq & ~mr;
        if (c[6] && (m_stall != {CW{1'b1}})) m_stall = m_stall + 1'b1;
        if (c[2] && (m_flush != {CW{1'b1}})) m_flush = m_flush + 1'b1;
        case (m_state)
            2'd0: if (busy) begin m_state = 2'd1; m_wait = 1; end
            2'd1: begin
                if (!busy) begin
                    m_state = 2'd0; m_wait = 0;
                end else if (m_wait == TO) begin
                    m_state = 2'd2; m_err = 1'b1;
                end else begin
                    m_wait = m_wait + 1;
                end
            end
            2'd2: if (ce) begin m_state = 2'd0; m_err = 1'b0; m_wait = 0; end
            default: m_state = 2'd0;
        endcase
    endtask

    // Called just after a rising edge: drive, predict, sample on the falling edge, advance.
    task automatic step(input logic hz, input logic br, input logic mq,
                        input logic mr, input logic ce);
        exp_t e;
        exp_t h;
        hazard_detected = hz;
        branch_taken    = br;
        mem_req         = mq;
        mem_ready       = mr;
        clr_err         = ce;
        e.ctrl  = model_ctrl(hz, br, mq, mr);
        e.st    = m_state;
        e.stall = m_stall;
        e.flush = m_flush;
        e.terr  = m_err;
        sb.push_back(e);
        @(negedge clk);
        h = sb.pop_front();
        check("ctrl",  32'(ctrl),         32'(h.ctrl));
        check("state", 32'(state),        32'(h.st));
        check("stall", 32'(stall_cycles), 32'(h.stall));
        check("flush", 32'(flush_events), 32'(h.flush));
        check("terr",  32'(timeout_err),  32'(h.terr));
        @(posedge clk);
        model_advance(hz, br, mq, mr, ce);
        #1;
    endtask

    // Assert reset asynchronously, check cleared state without a clock edge, then release.
    task automatic do_reset();
        rst = 1'b0;
        #1;
        model_reset();
        check("rst_state", 32'(state),        32'd0);
        check("rst_stall", 32'(stall_cycles), 32'd0);
        check("rst_flush", 32'(flush_events), 32'd0);
        check("rst_terr",  32'(timeout_err),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        rst             = 1'b1;
        hazard_detected = 1'b0;
        branch_taken    = 1'b0;
        mem_req         = 1'b0;
        mem_ready       = 1'b0;
        clr_err         = 1'b0;
        model_reset();
        #2;
        do_reset();
        check("rst_ctrl_idle", 32'(ctrl), 32'd0);

        // Two hazard cycles
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("hazard_stall2", 32'(stall_cycles), 32'd2);

        // Branch wins over hazard
        do_reset();
        step(1, 1, 0, 0, 0);
        check("br_hz_flush1", 32'(flush_events), 32'd1);
        check("br_hz_stall0", 32'(stall_cycles), 32'd0);

        // Memory stall with branch held throughout
        do_reset();
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        hazard_detected = 1'b0; branch_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b1;
        #1;
        check("ready_flush", 32'(flush_if_id), 32'd1);
        step(0, 1, 1, 1, 0);
        check("ready_state_run", 32'(state),        32'd0);
        check("ready_stall3",    32'(stall_cycles), 32'd3);
        // Ready in the same cycle as the request: no stall; clr_err ignored in RUN
        step(0, 0, 1, 1, 1);
        step(0, 0, 1, 1, 0);
        check("req_rdy_stall", 32'(stall_cycles), 32'd3);

        // Timeout into ERR
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);
        check("to_state_err", 32'(state),       32'd2);
        check("to_err_flag",  32'(timeout_err), 32'd1);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        check("clr_state_run", 32'(state),       32'd0);
        check("clr_err_flag",  32'(timeout_err), 32'd0);

        // Saturation of the stall counter
        do_reset();
        for (int i = 0; i < 20; i++) step(1, 0, 0, 0, 0);
        check("stall_sat15", 32'(stall_cycles), 32'd15);

        // Async reset mid-MEM_WAIT, outputs still follow inputs during reset
        do_reset();
        step(0, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0);
        check("pre_rst_memwait", 32'(state), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check("mid_rst_state", 32'(state),        32'd0);
        check("mid_rst_stall", 32'(stall_cycles), 32'd0);
        check("mid_rst_ctrl",  32'(ctrl),         32'h79);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Random traffic, reset between segments
        for (int seg = 0; seg < 6; seg++) begin
            do_reset();
            for (int i = 0; i < 30; i++) begin
                step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 4) == 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipeline_controller.md
PIPELINE_CONTROLLER -- requirements
Module: pipeline_controller

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 255: maximum memory-stall cycles before the error state.
REQ-002 SHALL have parameter CNT_W, default 16: width of the statistic counters.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port hazard_detected  input  1: RAW hazard flag from the ID-stage hazard unit.
REQ-006 SHALL have port branch_taken  input  1: taken branch resolved in EXE.
REQ-007 SHALL have port mem_req  input  1: MEM-stage instruction is a load or store.
REQ-008 SHALL have port mem_ready  input  1: memory completes the access this cycle.
REQ-009 SHALL have port clr_err  input  1: clears the error state.
REQ-010 SHALL have ports freeze_pc, freeze_if_id, freeze_id_exe, freeze_exe_mem  output  1 each: hold the PC or the named pipeline register.
REQ-011 SHALL have ports flush_if_id, bubble_id_exe, bubble_mem_wb  output  1 each: load a NOP (WB_en=0, MEM_W/R=0) into the named register.
REQ-012 SHALL have port state  output  2: current FSM state.
REQ-013 SHALL have ports stall_cycles, flush_events  output  CNT_W each: saturating statistics.
REQ-014 SHALL have port timeout_err  output  1: sticky memory-timeout flag.

Function
REQ-015 SHALL compute mem_busy = mem_req & ~mem_ready combinationally.
REQ-016 SHALL implement FSM states RUN=00, MEM_WAIT=01 and ERR=10; encoding 11 is unreachable and SHALL go to RUN.
REQ-017 RUN: mem_busy -> MEM_WAIT with wait_cnt=1; otherwise stay in RUN.
REQ-018 MEM_WAIT: ~mem_busy -> RUN with wait_cnt=0.
REQ-019 MEM_WAIT: mem_busy and wait_cnt==MEM_TIMEOUT -> ERR and set timeout_err.
REQ-020 MEM_WAIT: mem_busy otherwise -> wait_cnt+1.
REQ-021 ERR: clr_err -> RUN, clearing timeout_err and wait_cnt; otherwise stay in ERR; clr_err is ignored outside ERR.
REQ-022 Output decode SHALL be combinational (same-cycle) with priority freeze_all > branch > hazard.
REQ-023 freeze_all = mem_busy | (state==ERR): freeze_pc, freeze_if_id, freeze_id_exe and freeze_exe_mem SHALL be 1, bubble_mem_wb=1, flush_if_id=0 and bubble_id_exe=0.
REQ-024 Otherwise, branch_taken SHALL assert flush_if_id=1 and bubble_id_exe=1 with no freezes; hazard_detected is ignored because the ID instruction is squashed.
REQ-025 Otherwise, hazard_detected SHALL assert freeze_pc=1, freeze_if_id=1 and bubble_id_exe=1.
REQ-026 Otherwise, all control outputs SHALL be 0.
REQ-027 mem_req and mem_ready both 1 in the same cycle SHALL cause no stall and no state change.
REQ-028 A branch_taken held during a freeze SHALL take effect in the first unfrozen cycle, with no buffering in this block.
REQ-029 stall_cycles SHALL increment on every cycle with freeze_pc=1 and saturate at all-ones.
REQ-030 flush_events SHALL increment on every cycle with flush_if_id=1 and saturate at all-ones.
REQ-031 wait_cnt width SHALL be clog2(MEM_TIMEOUT+1); it is internal and never wraps.

Reset
REQ-032 rst low SHALL asynchronously force state=RUN, wait_cnt=0, timeout_err=0, stall_cycles=0 and flush_events=0, including mid-MEM_WAIT or in ERR.
REQ-033 During reset, combinational outputs SHALL follow the inputs per REQ-022..026 with state=RUN.

Structure
REQ-034 Package pipeline_ctrl_pkg SHALL hold the state enum (RUN, MEM_WAIT, ERR) and the default constants MEM_TIMEOUT and CNT_W.
REQ-035 One sub-module, sat_counter (parameter W; inputs clk, rst, inc; output count), SHALL be instantiated twice.
REQ-036 The FSM and output decode SHALL stay in pipeline_controller.

Verification
REQ-037 hazard_detected=1 for 2 cycles, other inputs 0 -> freeze_pc, freeze_if_id and bubble_id_exe =1 for both cycles; stall_cycles=2.
REQ-038 branch_taken=1 and hazard_detected=1 in the same cycle -> flush_if_id=1, bubble_id_exe=1, freeze_pc=0; flush_events=1.
REQ-039 mem_req=1 with mem_ready low for 3 cycles then high, and branch_taken=1 throughout:
- 3 frozen cycles with bubble_mem_wb=1 and flush_if_id=0;
- on the ready cycle, flush_if_id=1 and state returns to RUN;
- stall_cycles=3.
REQ-040 MEM_TIMEOUT=4, mem_req=1, mem_ready=0 continuously:
- state=ERR and timeout_err=1 after the 5th edge following the first busy cycle;
- all freezes stay held with mem_req then 0;
- clr_err=1 -> RUN next edge and timeout_err=0.
REQ-041 CNT_W=4, 20 consecutive hazard cycles -> stall_cycles=15 held.
REQ-042 rst pulsed low mid-MEM_WAIT -> state=RUN and counters=0 immediately, without waiting for a clock edge.
